// File: rtl/dvp_pkg.sv
// Shared types and default timing for the DVP camera-bus transmitter.
package dvp_pkg;

    localparam int DVP_DATA_WIDTH   = 8;
    localparam int PIXEL_W          = 2 * DVP_DATA_WIDTH;
    localparam int DVP_H_ACTIVE     = 640;
    localparam int DVP_V_ACTIVE     = 480;
    localparam int DVP_H_BLANK      = 16;
    localparam int DVP_VSYNC_CYCLES = 8;
    localparam int DVP_V_BACK       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACT_MSB,
        ST_ACT_LSB,
        ST_HBLANK
    } dvp_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dvp_tx_pattern_gen.sv
// Ramp source {line[7:0], col[7:0]}; exists only when DVP_TX_TEST_PATTERN_EN is defined.
`ifdef DVP_TX_TEST_PATTERN_EN
module dvp_tx_pattern_gen
    import dvp_pkg::*;
#(
    parameter int PW = PIXEL_W,
    parameter int LW = 1,
    parameter int CW = 1
) (
    input  logic [LW-1:0] line_i,
    input  logic [CW-1:0] col_i,
    output logic [PW-1:0] pixel_o
);

    logic [7:0] line8;
    logic [7:0] col8;

    assign line8   = 8'(line_i);
    assign col8    = 8'(col_i);
    assign pixel_o = PW'({line8, col8});

endmodule
`endif

// File: rtl/dvp_stream_tx.sv
// DVP transmitter: FWFT FIFO pixels onto PCLK/VSYNC/HREF/8-bit bus, MSB byte first.
// Optional ramp source under DVP_TX_TEST_PATTERN_EN (adds pattern_en_i).
module dvp_stream_tx
    import dvp_pkg::*;
#(
    parameter int DATA_WIDTH   = DVP_DATA_WIDTH,
    parameter int H_ACTIVE     = DVP_H_ACTIVE,
    parameter int V_ACTIVE     = DVP_V_ACTIVE,
    parameter int H_BLANK      = DVP_H_BLANK,
    parameter int VSYNC_CYCLES = DVP_VSYNC_CYCLES,
    parameter int V_BACK       = DVP_V_BACK
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    enable_i,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic                    pattern_en_i,
`endif
    input  logic                    pixel_valid_i,
    input  logic [2*DATA_WIDTH-1:0] pixel_data_i,
    output logic                    pixel_ready_o,
    output logic                    cam_pclk_o,
    output logic [DATA_WIDTH-1:0]   cam_half_pixel_o,
    output logic                    cam_href_o,
    output logic                    cam_vsync_o,
    output logic                    frame_done_o,
    output logic                    underrun_o
);

    localparam int PW   = 2 * DATA_WIDTH;
    localparam int CW   = cnt_w(H_ACTIVE);
    localparam int LW   = cnt_w(V_ACTIVE);
    localparam int BMAX = (VSYNC_CYCLES > V_BACK) ?
                          ((VSYNC_CYCLES > H_BLANK) ? VSYNC_CYCLES : H_BLANK) :
                          ((V_BACK > H_BLANK) ? V_BACK : H_BLANK);
    localparam int BW   = cnt_w(BMAX);

    dvp_state_e            state_q, state_d;
    logic                  ph_q;
    logic [CW-1:0]         col_q, col_d;
    logic [LW-1:0]         line_q, line_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic                  vsync_q, vsync_d;
    logic                  href_q, href_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] lsb_q, lsb_d;
    logic                  underrun_q, underrun_d;
    logic                  frame_done_q;
    logic                  frame_end;
    logic                  enter_msb;
    logic                  tick;
    logic                  pattern_sel;
    logic [PW-1:0]         pixel_src;

    assign tick = ph_q;

`ifdef DVP_TX_TEST_PATTERN_EN
    logic [PW-1:0] ramp_pixel;

    // The ramp is evaluated for the pixel being entered, so it sees next-state counters.
    dvp_tx_pattern_gen #(.PW(PW), .LW(LW), .CW(CW)) u_pattern_gen (
        .line_i  (line_d),
        .col_i   (col_d),
        .pixel_o (ramp_pixel)
    );

    assign pattern_sel = pattern_en_i;
    assign pixel_src   = pattern_en_i ? ramp_pixel : pixel_data_i;
`else
    assign pattern_sel = 1'b0;
    assign pixel_src   = pixel_data_i;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d    = state_q;
        col_d      = col_q;
        line_d     = line_q;
        blk_d      = blk_q;
        vsync_d    = vsync_q;
        href_d     = href_q;
        data_d     = data_q;
        lsb_d      = lsb_q;
        underrun_d = underrun_q;
        frame_end  = 1'b0;
        enter_msb  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                vsync_d = 1'b1;
                href_d  = 1'b0;
                data_d  = '0;
                if (enable_i) begin
                    state_d = ST_VSYNC;
                    blk_d   = '0;
                end
            end
            ST_VSYNC: begin
                if (blk_q == BW'(VSYNC_CYCLES - 1)) begin
                    state_d    = ST_VBACK;
                    blk_d      = '0;
                    line_d     = '0;
                    vsync_d    = 1'b0;
                    underrun_d = 1'b0;
                end else begin
                    blk_d = blk_q + BW'(1);
                end
            end
            ST_VBACK: begin
                if (blk_q == BW'(V_BACK - 1)) begin
                    enter_msb = 1'b1;
                    col_d     = '0;
                end else begin
                    blk_d = blk_q + BW'(1);
                end
            end
            ST_ACT_MSB: begin
                state_d = ST_ACT_LSB;
                data_d  = lsb_q;
            end
            ST_ACT_LSB: begin
                if (col_q == CW'(H_ACTIVE - 1)) begin
                    state_d = ST_HBLANK;
                    href_d  = 1'b0;
                    data_d  = '0;
                    blk_d   = '0;
                end else begin
                    enter_msb = 1'b1;
                    col_d     = col_q + CW'(1);
                end
            end
            ST_HBLANK: begin
                if (blk_q != BW'(H_BLANK - 1)) begin
                    blk_d = blk_q + BW'(1);
                end else if (line_q == LW'(V_ACTIVE - 1)) begin
                    frame_end = 1'b1;
                    vsync_d   = 1'b1;
                    blk_d     = '0;
                    state_d   = enable_i ? ST_VSYNC : ST_IDLE;
                end else begin
                    enter_msb = 1'b1;
                    line_d    = line_q + LW'(1);
                    col_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A missing FIFO word still occupies its slot: HREF timing never stretches.
        if (enter_msb) begin
            state_d = ST_ACT_MSB;
            href_d  = 1'b1;
            if (pattern_sel || pixel_valid_i) begin
                data_d = pixel_src[PW-1:DATA_WIDTH];
                lsb_d  = pixel_src[DATA_WIDTH-1:0];
            end else begin
                data_d     = '0;
                lsb_d      = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn_i) begin
            ph_q         <= 1'b0;
            state_q      <= ST_IDLE;
            col_q        <= '0;
            line_q       <= '0;
            blk_q        <= '0;
            vsync_q      <= 1'b1;
            href_q       <= 1'b0;
            data_q       <= '0;
            lsb_q        <= '0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ph_q         <= ~ph_q;
            frame_done_q <= tick & frame_end;
            if (tick) begin
                state_q    <= state_d;
                col_q      <= col_d;
                line_q     <= line_d;
                blk_q      <= blk_d;
                vsync_q    <= vsync_d;
                href_q     <= href_d;
                data_q     <= data_d;
                lsb_q      <= lsb_d;
                underrun_q <= underrun_d;
            end
        end
    end

    // Pop is combinational so the FIFO advances on exactly the tick that samples its head.
    assign pixel_ready_o    = resetn_i & tick & enter_msb & ~pattern_sel & pixel_valid_i;
    assign cam_pclk_o       = ph_q;
    assign cam_half_pixel_o = data_q;
    assign cam_href_o       = href_q;
    assign cam_vsync_o      = vsync_q;
    assign frame_done_o     = frame_done_q;
    assign underrun_o       = underrun_q;

endmodule

// File: tb/tb_dvp_stream_tx.sv
// Directed bench for dvp_stream_tx with a small geometry and a queue-based FWFT FIFO.
module tb_dvp_stream_tx;

    localparam int DW = 8;
    localparam int HA = 3;
    localparam int VA = 2;
    localparam int HB = 2;
    localparam int VS = 3;
    localparam int VB = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [15:0]   pixel_data = '0;
    logic          pixel_ready;
    logic          cam_pclk;
    logic [DW-1:0] cam_data;
    logic          cam_href;
    logic          cam_vsync;
    logic          frame_done;
    logic          underrun;
`ifdef DVP_TX_TEST_PATTERN_EN
    logic          pattern_en = 1'b0;
`endif

    dvp_stream_tx #(
        .DATA_WIDTH(DW), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_BLANK(HB), .VSYNC_CYCLES(VS), .V_BACK(VB)
    ) dut (
        .clk_i            (clk),
        .resetn_i         (resetn),
        .enable_i         (enable),
`ifdef DVP_TX_TEST_PATTERN_EN
        .pattern_en_i     (pattern_en),
`endif
        .pixel_valid_i    (pixel_valid),
        .pixel_data_i     (pixel_data),
        .pixel_ready_o    (pixel_ready),
        .cam_pclk_o       (cam_pclk),
        .cam_half_pixel_o (cam_data),
        .cam_href_o       (cam_href),
        .cam_vsync_o      (cam_vsync),
        .frame_done_o     (frame_done),
        .underrun_o       (underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] fifo[$];
    logic        pop_pend = 1'b0;
    logic [7:0]  bytes[$];
    int          runs[$];
    int          run = 0;
    int          period = 0;
    int          pops = 0;
    int          fd_period[$];
    int          fd_pops[$];

    // Receiver view: the PCLK-high half is where the rising edge samples the bus.
    always @(negedge clk) begin
        if (pixel_ready) begin
            pops++;
            pop_pend = 1'b1;
        end
        if (frame_done) begin
            fd_period.push_back(period);
            fd_pops.push_back(pops);
        end
        if (cam_pclk) begin
            period++;
            if (cam_href) begin
                bytes.push_back(cam_data);
                run++;
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            if (fifo.size() != 0) void'(fifo.pop_front());
            pop_pend = 1'b0;
        end
        pixel_valid = (fifo.size() != 0);
        pixel_data  = (fifo.size() != 0) ? fifo[0] : 16'h0000;
    end

    task automatic clear_log();
        bytes.delete();
        runs.delete();
        fd_period.delete();
        fd_pops.delete();
        run      = 0;
        period   = 0;
        pops     = 0;
        pop_pend = 1'b0;
    endtask

    task automatic start_reset();
        @(negedge clk);
        resetn = 1'b0;
        enable = 1'b0;
        fifo.delete();
        repeat (3) @(negedge clk);
        clear_log();
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_period.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (fd_period.size() < n) check("frame_done_timeout", 32'(fd_period.size()), 32'(n));
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pops < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (pops < n) check("pop_timeout", 32'(pops), 32'(n));
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp [12]);
        for (int i = 0; i < 12; i++)
            check($sformatf("%s_byte%0d", tag, i),
                  (i < bytes.size()) ? {24'h0, bytes[i]} : 32'hDEAD, {24'h0, exp[i]});
    endtask

    logic [7:0] exp_norm [12] = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'hFE, 8'hED,
                                  8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] exp_unr  [12] = '{8'hAB, 8'hCD, 8'h00, 8'h00, 8'h12, 8'h34,
                                  8'hFE, 8'hED, 8'hBE, 8'hEF, 8'h01, 8'h02};

    task automatic load_six();
        fifo = '{16'hABCD, 16'h1234, 16'hFEED, 16'hBEEF, 16'h0102, 16'h0304};
    endtask

    initial begin
        // Reset held 4 cycles: PCLK must not toggle, outputs sit at reset values.
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_pclk", 32'(cam_pclk), 32'd0);
        end
        check("rst_vsync",    32'(cam_vsync),   32'd1);
        check("rst_href",     32'(cam_href),    32'd0);
        check("rst_data",     32'(cam_data),    32'd0);
        check("rst_ready",    32'(pixel_ready), 32'd0);
        check("rst_fdone",    32'(frame_done),  32'd0);
        check("rst_underrun", 32'(underrun),    32'd0);

        // Normal frame, then a back-to-back second frame to measure length.
        start_reset();
        load_six();
        release_reset();
        wait_fd(1, 400);
        check_bytes("norm", exp_norm);
        check("norm_run0", (runs.size() > 0) ? 32'(runs[0]) : 32'hFFFF, 32'd6);
        check("norm_run1", (runs.size() > 1) ? 32'(runs[1]) : 32'hFFFF, 32'd6);
        check("norm_pops", (fd_pops.size() > 0) ? 32'(fd_pops[0]) : 32'hFFFF, 32'd6);
        @(negedge clk);
        check("norm_vsync_at_end", 32'(cam_vsync), 32'd1);
        check("norm_underrun", 32'(underrun), 32'd0);
        wait_fd(2, 400);
        check("frame_len", (fd_period.size() > 1) ? 32'(fd_period[1] - fd_period[0]) : 32'hFFFF,
              32'(VS + VB + VA * (2 * HA + HB)));

        // Second pixel missing from the FIFO.
        start_reset();
        fifo = '{16'hABCD};
        release_reset();
        wait_pops(1, 400);
        repeat (5) @(posedge clk);
        fifo.push_back(16'h1234);
        fifo.push_back(16'hFEED);
        fifo.push_back(16'hBEEF);
        fifo.push_back(16'h0102);
        @(negedge clk);
        check("unr_set", 32'(underrun), 32'd1);
        wait_fd(1, 400);
        check_bytes("unr", exp_unr);
        check("unr_pops", (fd_pops.size() > 0) ? 32'(fd_pops[0]) : 32'hFFFF, 32'd5);
        @(negedge clk);
        check("unr_sticky", 32'(underrun), 32'd1);
        repeat (7) @(negedge clk);
        check("unr_cleared_vback", 32'(underrun), 32'd0);

        // Enable dropped during line 0.
        start_reset();
        load_six();
        release_reset();
        begin
            int k = 0;
            while (bytes.size() < 2 && k < 400) begin
                @(posedge clk);
                k++;
            end
        end
        enable = 1'b0;
        wait_fd(1, 400);
        repeat (40) @(negedge clk);
        check("en_fd_count", 32'(fd_period.size()), 32'd1);
        check("en_pops", 32'(pops), 32'd6);
        check("en_bytes", 32'(bytes.size()), 32'd12);
        check("en_last_byte", (bytes.size() == 12) ? {24'h0, bytes[11]} : 32'hDEAD, 32'h04);
        check("en_idle_vsync", 32'(cam_vsync), 32'd1);
        check("en_idle_href", 32'(cam_href), 32'd0);

        // Reset pulsed during ACT_LSB of the first pixel.
        start_reset();
        load_six();
        release_reset();
        wait_pops(1, 400);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("rp_pre_data", 32'(cam_data), 32'hCD);
        check("rp_pre_ready", 32'(pixel_ready), 32'd0);
        @(negedge clk);
        check("rp_pclk", 32'(cam_pclk), 32'd0);
        check("rp_vsync", 32'(cam_vsync), 32'd1);
        check("rp_href", 32'(cam_href), 32'd0);
        check("rp_data", 32'(cam_data), 32'd0);
        check("rp_pops", 32'(pops), 32'd1);
        enable = 1'b0;
        fifo.delete();
        clear_log();
        load_six();
        release_reset();
        wait_fd(1, 400);
        check_bytes("rp", exp_norm);
        check("rp_frame_pops", (fd_pops.size() > 0) ? 32'(fd_pops[0]) : 32'hFFFF, 32'd6);

`ifdef DVP_TX_TEST_PATTERN_EN
        begin
            logic [7:0] exp_pat [12] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02,
                                         8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};
            start_reset();
            pattern_en = 1'b1;
            release_reset();
            wait_fd(1, 400);
            check_bytes("pat", exp_pat);
            check("pat_pops", 32'(pops), 32'd0);
            check("pat_underrun", 32'(underrun), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
